// File: rtl/mem_access_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit_if
//  Purpose  : Request/response and datamem bus bundle for mem_access_unit.
//             master = pipeline/memory side, slave = the access unit.
//  Revision : 1.0  initial release
// ============================================================================
interface mem_access_unit_if #(
    parameter int ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [31:0]       req_addr;
    logic [31:0]       req_wdata;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              resp_err;
    logic              readMem;
    logic              writeMem;
    logic [ADDR_W-1:0] R_addr;
    logic [ADDR_W-1:0] W_addr;
    logic [31:0]       W_data;
    logic [31:0]       R_data;

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, R_data,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  readMem, writeMem, R_addr, W_addr, W_data
    );

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, R_data,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output readMem, writeMem, R_addr, W_addr, W_data
    );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mem_access_unit
//  Purpose  : Load/store initiator between the MEM stage and word-only
//             datamem. Byte/halfword stores use read-modify-write; loads are
//             lane-extracted and sign/zero-extended; misaligned accesses and
//             the reserved size return an error response.
//  Config   : MEM_ACCESS_SUBWORD_EN enables byte/half accesses; without it
//             only word accesses are legal.
//  Revision : 1.0  initial release
// ============================================================================
module mem_access_unit #(
    parameter int ADDR_W = 10
) (
    input  wire logic           clk,
    input  wire logic           rst,
    mem_access_unit_if.slave    bus
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_READ      = 3'd1,
        S_WRITE     = 3'd2,
`ifdef MEM_ACCESS_SUBWORD_EN
        S_RMW_READ  = 3'd3,
        S_RMW_WRITE = 3'd4,
`endif
        S_RESP      = 3'd5
    } state_t;

    localparam logic [1:0] c_SIZE_BYTE = 2'b00;
    localparam logic [1:0] c_SIZE_HALF = 2'b01;
    localparam logic [1:0] c_SIZE_WORD = 2'b10;

    state_t             r_state;
    logic               r_read_mem;
    logic               r_write_mem;
    logic [ADDR_W-1:0]  r_raddr;
    logic [ADDR_W-1:0]  r_waddr;
    logic [31:0]        r_wdata_out;
    logic               r_resp_valid;
    logic               r_resp_err;
    logic [31:0]        r_resp_rdata;

    logic               w_hs;
    logic               w_err;
    logic [ADDR_W-1:0]  w_index;
    logic [31:0]        w_load_data;

`ifdef MEM_ACCESS_SUBWORD_EN
    // Request fields only needed after the handshake for sub-word handling
    logic [ADDR_W-1:0]  r_index;
    logic [1:0]         r_size;
    logic [1:0]         r_off;
    logic               r_signed;
    logic [31:0]        r_wdata;
    logic [7:0]         w_byte;
    logic [15:0]        w_half;
    logic [31:0]        w_merge_data;
`endif

    // High address bits wrap by design; the sign flag matters only for sub-word loads
    logic w_unused_inputs;
`ifdef MEM_ACCESS_SUBWORD_EN
    assign w_unused_inputs = &{1'b0, bus.req_addr[31:ADDR_W+2]};
`else
    assign w_unused_inputs = &{1'b0, bus.req_addr[31:ADDR_W+2], bus.req_signed};
`endif

    assign bus.req_ready  = (r_state == S_IDLE);
    assign bus.readMem    = r_read_mem;
    assign bus.writeMem   = r_write_mem;
    assign bus.R_addr     = r_raddr;
    assign bus.W_addr     = r_waddr;
    assign bus.W_data     = r_wdata_out;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_err   = r_resp_err;
    assign bus.resp_rdata = r_resp_rdata;

    assign w_hs    = bus.req_valid & (r_state == S_IDLE);
    assign w_index = bus.req_addr[ADDR_W+1:2];

    // Reject reserved size and misaligned addresses before any memory access
    always_comb begin
        w_err = 1'b0;
`ifdef MEM_ACCESS_SUBWORD_EN
        case (bus.req_size)
            c_SIZE_BYTE: w_err = 1'b0;
            c_SIZE_HALF: w_err = bus.req_addr[0];
            c_SIZE_WORD: w_err = (bus.req_addr[1:0] != 2'b00);
            default:     w_err = 1'b1;
        endcase
`else
        w_err = (bus.req_size != c_SIZE_WORD) || (bus.req_addr[1:0] != 2'b00);
`endif
    end

    // Lane extraction / extension for loads and lane merge for RMW stores
    always_comb begin
        w_load_data = bus.R_data;
`ifdef MEM_ACCESS_SUBWORD_EN
        w_byte       = bus.R_data[{r_off, 3'b000} +: 8];
        w_half       = bus.R_data[{r_off[1], 4'b0000} +: 16];
        w_merge_data = bus.R_data;
        case (r_size)
            c_SIZE_BYTE: begin
                w_load_data = {{24{r_signed & w_byte[7]}}, w_byte};
                w_merge_data[{r_off, 3'b000} +: 8] = r_wdata[7:0];
            end
            c_SIZE_HALF: begin
                w_load_data = {{16{r_signed & w_half[15]}}, w_half};
                w_merge_data[{r_off[1], 4'b0000} +: 16] = r_wdata[15:0];
            end
            default: begin
                w_load_data = bus.R_data;
            end
        endcase
`endif
    end

    // Control FSM; every bus output is a one-cycle registered pulse defaulting to 0
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_read_mem   <= 1'b0;
            r_write_mem  <= 1'b0;
            r_raddr      <= '0;
            r_waddr      <= '0;
            r_wdata_out  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
`ifdef MEM_ACCESS_SUBWORD_EN
            r_index      <= '0;
            r_size       <= '0;
            r_off        <= '0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
`endif
        end else begin
            r_read_mem   <= 1'b0;
            r_write_mem  <= 1'b0;
            r_raddr      <= '0;
            r_waddr      <= '0;
            r_wdata_out  <= '0;
            r_resp_valid <= 1'b0;
            r_resp_err   <= 1'b0;
            r_resp_rdata <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
`ifdef MEM_ACCESS_SUBWORD_EN
                        r_index  <= w_index;
                        r_size   <= bus.req_size;
                        r_off    <= bus.req_addr[1:0];
                        r_signed <= bus.req_signed;
                        r_wdata  <= bus.req_wdata;
`endif
                        if (w_err) begin
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                            r_resp_err   <= 1'b1;
                        end else if (!bus.req_write) begin
                            r_state    <= S_READ;
                            r_read_mem <= 1'b1;
                            r_raddr    <= w_index;
`ifdef MEM_ACCESS_SUBWORD_EN
                        end else if (bus.req_size != c_SIZE_WORD) begin
                            r_state    <= S_RMW_READ;
                            r_read_mem <= 1'b1;
                            r_raddr    <= w_index;
`endif
                        end else begin
                            r_state     <= S_WRITE;
                            r_write_mem <= 1'b1;
                            r_waddr     <= w_index;
                            r_wdata_out <= bus.req_wdata;
                        end
                    end
                end
                S_READ: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                    r_resp_rdata <= w_load_data;
                end
                S_WRITE: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
`ifdef MEM_ACCESS_SUBWORD_EN
                S_RMW_READ: begin
                    r_state     <= S_RMW_WRITE;
                    r_write_mem <= 1'b1;
                    r_waddr     <= r_index;
                    r_wdata_out <= w_merge_data;
                end
                S_RMW_WRITE: begin
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
`endif
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_access_unit
//  Purpose  : Directed self-checking bench for mem_access_unit with a
//             behavioural datamem model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

`ifdef MEM_ACCESS_SUBWORD_EN
    localparam bit c_SUB = 1'b1;
`else
    localparam bit c_SUB = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    mem_access_unit_if #(.ADDR_W(10)) bus ();

    mem_access_unit #(.ADDR_W(10)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // datamem model: combinational read, write on rising edge, plus a bench preload port
    logic [31:0] mem [0:1023];
    logic        poke_en   = 1'b0;
    logic [9:0]  poke_addr = '0;
    logic [31:0] poke_data = '0;
    always @(posedge clk) begin
        if (bus.writeMem)
            mem[bus.W_addr] <= bus.W_data;
        else if (poke_en)
            mem[poke_addr] <= poke_data;
    end
    assign bus.R_data = bus.readMem ? mem[bus.R_addr] : 32'hBAD0_BAD0;

    // strobe activity monitor
    int rd_cnt = 0, wr_cnt = 0, both_cnt = 0, leak_cnt = 0;
    always @(negedge clk) begin
        if (bus.readMem) rd_cnt++;
        if (bus.writeMem) wr_cnt++;
        if (bus.readMem && bus.writeMem) both_cnt++;
        if (!bus.readMem && bus.R_addr != 0) leak_cnt++;
        if (!bus.writeMem && (bus.W_addr != 0 || bus.W_data != 0)) leak_cnt++;
    end

    // handshake log
    int cyc = 0;
    int hs_q[$];
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst && bus.req_valid && bus.req_ready) hs_q.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic poke(input logic [9:0] a, input logic [31:0] d);
        @(negedge clk);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        @(negedge clk);
        poke_en = 1'b0;
    endtask

    task automatic wait_idle();
        int g = 0;
        @(negedge clk);
        while (!bus.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (g >= 20) chk("idle_timeout", 32'd0, 32'd1);
    endtask

    // One request; returns response data, error flag, latency and strobe counts
    task automatic do_req(input logic wr, input logic [1:0] sz, input logic sg,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int d_rd, output int d_wr);
        int rd0, wr0;
        wait_idle();
        rd0 = rd_cnt; wr0 = wr_cnt;
        bus.req_write = wr; bus.req_size = sz; bus.req_signed = sg;
        bus.req_addr = addr; bus.req_wdata = wd; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.req_addr = 32'hFFFF_FFFF; bus.req_wdata = ~wd;
        bus.req_size = ~sz; bus.req_signed = ~sg; bus.req_write = ~wr;
        lat = 0; rdata = '0; err = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            if (bus.resp_valid) begin
                lat = i; rdata = bus.resp_rdata; err = bus.resp_err;
                break;
            end
            @(posedge clk); #1;
        end
        if (lat == 0) chk("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
        d_rd = rd_cnt - rd0;
        d_wr = wr_cnt - wr0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat, nrd, nwr, pulses, q0;

    initial begin
        bus.req_valid = 1'b1; bus.req_write = 1'b0; bus.req_size = 2'b10;
        bus.req_signed = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

        // Reset with a request pending: it must be ignored
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_readMem",    {31'd0, bus.readMem},    32'd0);
        chk("rst_writeMem",   {31'd0, bus.writeMem},   32'd0);
        chk("rst_R_addr",     {22'd0, bus.R_addr},     32'd0);
        chk("rst_W_data",     bus.W_data,              32'd0);
        chk("rst_ready",      {31'd0, bus.req_ready},  32'd1);
        bus.req_valid = 1'b0;
        rst = 1'b0;

        // Word store then word load
        do_req(1'b1, 2'b10, 1'b0, 32'h010, 32'hDEAD_BEEF, rd, er, lat, nrd, nwr);
        chk("sw_lat", lat, 32'd2);
        chk("sw_err", {31'd0, er}, 32'd0);
        chk("sw_rdata", rd, 32'd0);
        chk("sw_nwr", nwr, 32'd1);
        chk("sw_mem", mem[4], 32'hDEAD_BEEF);
        do_req(1'b0, 2'b10, 1'b0, 32'h010, 32'h0, rd, er, lat, nrd, nwr);
        chk("lw_lat", lat, 32'd2);
        chk("lw_rdata", rd, 32'hDEAD_BEEF);
        chk("lw_nrd", nrd, 32'd1);

        // Byte store via read-modify-write
        poke(10'd4, 32'h1122_3344);
        do_req(1'b1, 2'b00, 1'b0, 32'h011, 32'h0000_00AB, rd, er, lat, nrd, nwr);
        chk("sb_err", {31'd0, er}, c_SUB ? 32'd0 : 32'd1);
        chk("sb_lat", lat, c_SUB ? 32'd3 : 32'd1);
        chk("sb_nrd", nrd, c_SUB ? 32'd1 : 32'd0);
        chk("sb_nwr", nwr, c_SUB ? 32'd1 : 32'd0);
        chk("sb_mem", mem[4], c_SUB ? 32'h1122_AB44 : 32'h1122_3344);

        // Half store to the upper lane
        do_req(1'b1, 2'b01, 1'b0, 32'h012, 32'hFFFF_5A6B, rd, er, lat, nrd, nwr);
        chk("sh_mem", mem[4], c_SUB ? 32'h5A6B_AB44 : 32'h1122_3344);

        // Sub-word loads with extension
        poke(10'd4, 32'h80FF_0000);
        do_req(1'b0, 2'b00, 1'b1, 32'h012, 32'h0, rd, er, lat, nrd, nwr);
        chk("lb_s", rd, c_SUB ? 32'hFFFF_FFFF : 32'd0);
        chk("lb_s_lat", lat, c_SUB ? 32'd2 : 32'd1);
        do_req(1'b0, 2'b00, 1'b0, 32'h012, 32'h0, rd, er, lat, nrd, nwr);
        chk("lb_u", rd, c_SUB ? 32'h0000_00FF : 32'd0);
        do_req(1'b0, 2'b00, 1'b1, 32'h013, 32'h0, rd, er, lat, nrd, nwr);
        chk("lb_s3", rd, c_SUB ? 32'hFFFF_FF80 : 32'd0);
        do_req(1'b0, 2'b01, 1'b1, 32'h012, 32'h0, rd, er, lat, nrd, nwr);
        chk("lh_s", rd, c_SUB ? 32'hFFFF_80FF : 32'd0);
        do_req(1'b0, 2'b01, 1'b0, 32'h012, 32'h0, rd, er, lat, nrd, nwr);
        chk("lh_u", rd, c_SUB ? 32'h0000_80FF : 32'd0);
        chk("lh_u_err", {31'd0, er}, c_SUB ? 32'd0 : 32'd1);

        // Error cases: no strobes, memory unchanged
        do_req(1'b1, 2'b01, 1'b0, 32'h013, 32'h1234_5678, rd, er, lat, nrd, nwr);
        chk("e_sh_err", {31'd0, er}, 32'd1);
        chk("e_sh_lat", lat, 32'd1);
        chk("e_sh_strb", nrd + nwr, 32'd0);
        chk("e_sh_mem", mem[4], 32'h80FF_0000);
        do_req(1'b0, 2'b10, 1'b0, 32'h002, 32'h0, rd, er, lat, nrd, nwr);
        chk("e_lw_err", {31'd0, er}, 32'd1);
        chk("e_lw_lat", lat, 32'd1);
        chk("e_lw_rdata", rd, 32'd0);
        do_req(1'b0, 2'b11, 1'b0, 32'h010, 32'h0, rd, er, lat, nrd, nwr);
        chk("e_sz3_err", {31'd0, er}, 32'd1);
        chk("e_sz3_strb", nrd + nwr, 32'd0);

        // Reset right after the handshake of a byte store
        poke(10'd5, 32'h5566_7788);
        wait_idle();
        q0 = wr_cnt;
        bus.req_write = 1'b1; bus.req_size = 2'b00; bus.req_signed = 1'b0;
        bus.req_addr = 32'h014; bus.req_wdata = 32'h99; bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("ra_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("ra_resp", {31'd0, bus.resp_valid}, 32'd0);
        repeat (4) @(negedge clk);
        chk("ra_nwr", wr_cnt - q0, 32'd0);
        chk("ra_mem", mem[5], 32'h5566_7788);

        // Back-to-back loads with valid held, address wraps to word 0
        poke(10'd0, 32'hCAFE_F00D);
        wait_idle();
        q0 = hs_q.size();
        pulses = 0;
        bus.req_write = 1'b0; bus.req_size = 2'b10; bus.req_signed = 1'b0;
        bus.req_addr = 32'h1000; bus.req_valid = 1'b1;
        for (int i = 0; i < 30 && pulses < 3; i++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                pulses++;
                chk("b2b_rdata", bus.resp_rdata, 32'hCAFE_F00D);
            end
        end
        bus.req_valid = 1'b0;
        chk("b2b_pulses", pulses, 32'd3);
        if (hs_q.size() >= q0 + 3) begin
            chk("b2b_gap1", hs_q[q0+1] - hs_q[q0], 32'd3);
            chk("b2b_gap2", hs_q[q0+2] - hs_q[q0+1], 32'd3);
        end else begin
            chk("b2b_hs_count", hs_q.size() - q0, 32'd3);
        end

        repeat (3) @(negedge clk);
        chk("never_both", both_cnt, 32'd0);
        chk("addr_data_leak", leak_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
